// File: rtl/blink_mem_arb.sv
// blink_mem_arb -- shares one asynchronous SRAM between a Z80 CPU and an LCD
// fetch engine.
//
// Each access holds ram_ce_n low for ACC_CYCLES clocks. Every access is
// followed by at least one IDLE cycle so the bus can turn around. When both
// requesters ask at once, the one not served last time wins.
//
// Ports
//   clk, reset_n           : system clock, asynchronous active-low reset
//   cpu_req/cpu_we/cpu_a/  : CPU request, write flag, byte address, write data
//   cpu_do
//   cpu_di                 : last byte read by the CPU (not changed by writes)
//   cpu_wait_n             : Z80 wait line, low while a CPU request is stalled
//   lcd_req/lcd_a          : LCD read request and address
//   lcd_ack/lcd_data       : one-cycle acknowledge with the fetched byte
//   ram_a/ram_do/ram_di    : SRAM address, write data, read data
//   ram_ce_n/oe_n/we_n     : SRAM strobes, all registered
module blink_mem_arb #(
  parameter int unsigned ACC_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  input  logic        lcd_req,
  input  logic [18:0] lcd_a,
  output logic        lcd_ack,
  output logic [7:0]  lcd_data,
  output logic [18:0] ram_a,
  output logic [7:0]  ram_do,
  input  logic [7:0]  ram_di,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    CPU_DONE = 2'd2,
    LCD_ACC  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACC_CYCLES - 1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        last_grant_r, last_grant_s;  // 1 = LCD was served last
  logic        we_r, we_s;                  // current CPU access is a write
  logic        grant_cpu_s, grant_lcd_s;
  logic        in_acc_s, last_cyc_s;
  logic        ce_s, oe_s, wen_s, lcd_ack_s;
  logic [18:0] ram_a_s;
  logic [7:0]  ram_do_s, cpu_di_s, lcd_data_s;

  assign in_acc_s   = (state_r == CPU_ACC) || (state_r == LCD_ACC);
  assign last_cyc_s = in_acc_s && (cnt_r == LAST_CNT);

  // The CPU is stalled from its first request cycle until CPU_DONE; during
  // reset the line is forced high so the Z80 is never held off.
  assign cpu_wait_n = reset_n ? ~(cpu_req && (state_r != CPU_DONE)) : 1'b1;

  // Arbitration: requests are only looked at in IDLE; ties go round-robin.
  always_comb begin
    grant_cpu_s = 1'b0;
    grant_lcd_s = 1'b0;
    if (state_r == IDLE) begin
      if (cpu_req && lcd_req) begin
        if (last_grant_r) begin
          grant_cpu_s = 1'b1;
        end else begin
          grant_lcd_s = 1'b1;
        end
      end else if (cpu_req) begin
        grant_cpu_s = 1'b1;
      end else if (lcd_req) begin
        grant_lcd_s = 1'b1;
      end else begin
        grant_cpu_s = 1'b0;
      end
    end else begin
      grant_cpu_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_cpu_s) begin
          state_s = CPU_ACC;
        end else if (grant_lcd_s) begin
          state_s = LCD_ACC;
        end else begin
          state_s = IDLE;
        end
      end
      CPU_ACC: begin
        // A CPU that gave up mid-access does not need the handshake state.
        if (last_cyc_s) begin
          state_s = cpu_req ? CPU_DONE : IDLE;
        end else begin
          state_s = CPU_ACC;
        end
      end
      CPU_DONE: begin
        state_s = cpu_req ? CPU_DONE : IDLE;
      end
      LCD_ACC: begin
        state_s = last_cyc_s ? IDLE : LCD_ACC;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered SRAM port and data captures.
  always_comb begin
    cnt_s        = 4'd0;
    last_grant_s = last_grant_r;
    we_s         = we_r;
    ce_s         = 1'b1;
    oe_s         = 1'b1;
    wen_s        = 1'b1;
    ram_a_s      = ram_a;
    ram_do_s     = ram_do;
    cpu_di_s     = cpu_di;
    lcd_data_s   = lcd_data;
    lcd_ack_s    = 1'b0;
    if (grant_cpu_s) begin
      ce_s         = 1'b0;
      oe_s         = cpu_we;
      wen_s        = 1'b1;      // write strobe waits one cycle for address setup
      ram_a_s      = cpu_a;
      ram_do_s     = cpu_do;
      we_s         = cpu_we;
      last_grant_s = 1'b0;
    end else if (grant_lcd_s) begin
      ce_s         = 1'b0;
      oe_s         = 1'b0;
      wen_s        = 1'b1;
      ram_a_s      = lcd_a;
      we_s         = 1'b0;
      last_grant_s = 1'b1;
    end else if (in_acc_s && !last_cyc_s) begin
      ce_s  = 1'b0;
      oe_s  = we_r;
      wen_s = ~we_r;
      cnt_s = cnt_r + 4'd1;
    end else if (last_cyc_s) begin
      // Strobes return high; read data is taken at the edge ending the access.
      if (state_r == LCD_ACC) begin
        lcd_data_s = ram_di;
        lcd_ack_s  = 1'b1;
      end else if (!we_r) begin
        cpu_di_s = ram_di;
      end else begin
        cpu_di_s = cpu_di;
      end
    end else begin
      cnt_s = 4'd0;
    end
  end

  // Datapath and SRAM port registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r        <= 4'd0;
      last_grant_r <= 1'b1;
      we_r         <= 1'b0;
      ram_ce_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
      ram_a        <= 19'd0;
      ram_do       <= 8'd0;
      cpu_di       <= 8'hFF;
      lcd_data     <= 8'd0;
      lcd_ack      <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      last_grant_r <= last_grant_s;
      we_r         <= we_s;
      ram_ce_n     <= ce_s;
      ram_oe_n     <= oe_s;
      ram_we_n     <= wen_s;
      ram_a        <= ram_a_s;
      ram_do       <= ram_do_s;
      cpu_di       <= cpu_di_s;
      lcd_data     <= lcd_data_s;
      lcd_ack      <= lcd_ack_s;
    end
  end

endmodule

// File: doc/blink_mem_arb.md
BLINK_MEM_ARB -- requirements
Module: blink_mem_arb

Interface
REQ-001 SHALL have parameter ACC_CYCLES, default 3: number of clocks ram_ce_n is held low per SRAM access; legal values 2..15.
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cpu_req, input, 1: Z80 requests RAM (decoded from mreq and RAM select); held high until cpu_wait_n is seen high.
REQ-005 SHALL have port cpu_we, input, 1: 1 = write, 0 = read; stable while cpu_req is high.
REQ-006 SHALL have port cpu_a, input, 19: CPU RAM byte address.
REQ-007 SHALL have port cpu_do, input, 8: CPU write data.
REQ-008 SHALL have port cpu_di, output, 8: captured CPU read data.
REQ-009 SHALL have port cpu_wait_n, output, 1: Z80 wait line; low stalls the CPU.
REQ-010 SHALL have port lcd_req, input, 1: LCD fetch request; read-only.
REQ-011 SHALL have port lcd_a, input, 19: LCD fetch address.
REQ-012 SHALL have port lcd_ack, output, 1: one-clock pulse; lcd_data valid in the same cycle.
REQ-013 SHALL have port lcd_data, output, 8: LCD fetch data.
REQ-014 SHALL have ports ram_a (output, 19), ram_do (output, 8), ram_di (input, 8), ram_ce_n, ram_oe_n, ram_we_n (outputs, 1): external SRAM port.

Function
REQ-015 SHALL implement FSM states IDLE, CPU_ACC, CPU_DONE and LCD_ACC.
REQ-016 SHALL sample requests only in IDLE; any access ends with one IDLE cycle for bus turnaround.
REQ-017 SHALL grant CPU when only cpu_req is high, LCD when only lcd_req is high, and the requester not granted last when both are high (last_grant round-robin bit).
REQ-018 SHALL, on grant at edge k, register ram_a, ram_do and strobes so that ram_ce_n is low for cycles k+1..k+ACC_CYCLES; an access counter of 4 bits counts 0..ACC_CYCLES-1.
REQ-019 SHALL, on reads, hold ram_oe_n low and ram_we_n high for the whole access.
REQ-020 SHALL, on CPU writes, hold ram_oe_n high, hold ram_we_n high in the first access cycle and low in the remaining cycles, with ram_do = cpu_do throughout.
REQ-021 SHALL capture ram_di at the edge ending the last access cycle into cpu_di (CPU read) or lcd_data (LCD read).
REQ-022 SHALL assert lcd_ack for exactly the one cycle following that capture.
REQ-023 SHALL, after a CPU access, enter CPU_DONE and remain there while cpu_req is high, returning to IDLE when cpu_req is low.
REQ-024 SHALL drive cpu_wait_n = NOT(cpu_req AND state != CPU_DONE), so the CPU is stalled from the first cpu_req cycle until CPU_DONE.
REQ-025 SHALL keep ram_ce_n, ram_oe_n and ram_we_n high in IDLE and CPU_DONE.
REQ-026 SHALL complete an LCD access and pulse lcd_ack even if lcd_req drops mid-access.
REQ-027 SHALL complete a CPU access if cpu_req drops mid-access, update cpu_di, and skip CPU_DONE, returning directly to IDLE.
REQ-028 SHALL treat a request arriving during an access as pending; it is granted in the next IDLE.
REQ-029 SHALL leave cpu_di unchanged by CPU writes.

Reset
REQ-030 SHALL, while reset_n is low and independent of clk, force:
- state IDLE; counter 0; last_grant = LCD (so CPU wins the first tie);
- ram_ce_n, ram_oe_n, ram_we_n = 1; ram_a = 0; ram_do = 0;
- cpu_di = 8'hFF; lcd_data = 0; lcd_ack = 0; cpu_wait_n = 1.
REQ-031 SHALL abort any access in flight on reset, with the strobes going high immediately.

Verification
REQ-032 CPU read, ACC_CYCLES=3, cpu_a=19'h00123, ram_di=8'h5A -> ce_n/oe_n low for exactly 3 clocks, cpu_wait_n low until CPU_DONE, then cpu_di=8'h5A and cpu_wait_n high.
REQ-033 CPU write, cpu_a=19'h7FFFF, cpu_do=8'hC3 -> we_n low in cycles 2-3 only, oe_n high throughout, ram_do=8'hC3, cpu_di unchanged.
REQ-034 cpu_req and lcd_req rise together in three consecutive rounds after reset -> grants are CPU, LCD, CPU, each access separated by one IDLE cycle.
REQ-035 LCD read, lcd_a=19'h40000, ram_di=8'hA5, lcd_req dropped after 1 clock -> access completes, lcd_ack one-cycle pulse with lcd_data=8'hA5.
REQ-036 reset_n pulsed low in the 2nd cycle of a CPU write -> strobes high asynchronously; after release all outputs equal their REQ-030 values and the next request is served normally.
